// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 block encryptor, one round per clock, valid/ready on input and output.
// Define AES_ENC_CBC_EN to add the CBC chain register and the iv_in/iv_load ports.
module aes_encrypt_core #(
    parameter int KEY_BITS = 128,
    parameter int NK       = KEY_BITS / 32,
    parameter int NR       = NK + 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic [127:0]        pt_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [127:0]        ct_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
`ifdef AES_ENC_CBC_EN
    ,
    input  logic [127:0]        iv_in,
    input  logic                iv_load
`endif
);

    localparam int NW = 4 * (NR + 1);
    localparam int KW = 128 * (NR + 1);
    localparam logic [3:0] RND_LAST = 4'(NR - 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_encrypt_core: KEY_BITS must be 128, 192 or 256");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as x^254 in GF(2^8) followed by the affine map, rather than a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, v;
        sq = x;
        v  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            v  = gmul(v, sq);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Byte n of the block is row n%4, column n/4, MSB first.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // Round key i lands at keys[128*(NR-i) +: 128], so round key 0 is the top slice.
    function automatic logic [KW-1:0] expand_key(input logic [KEY_BITS-1:0] k);
        logic [31:0] w [NW];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [KW-1:0] r;
        rc = 8'h01;
        for (int i = 0; i < NK; i++) w[i] = k[KEY_BITS - 1 - 32*i -: 32];
        for (int i = NK; i < NW; i++) begin
            t = w[i-1];
            if (i % NK == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-NK] ^ t;
        end
        for (int i = 0; i <= NR; i++)
            r[KW - 1 - 128*i -: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        return r;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [127:0]          st_q, st_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [3:0]            rnd_q, rnd_d;
    logic [127:0]          ct_q, ct_d;
    logic                  out_valid_q, out_valid_d;
    logic [127:0]          chain_src;
    logic [KW-1:0]         keys_w;
    logic [127:0]          rk_sel, rk0_in, sr_w, round_w, final_w;
    logic                  in_ready_c, in_hs, out_hs;

    assign keys_w  = expand_key(key_q);
    assign rk0_in  = key_in[KEY_BITS-1 -: 128];
    assign sr_w    = shift_rows(sub_bytes(st_q));
    assign round_w = mix_columns(sr_w) ^ rk_sel;
    assign final_w = sr_w ^ keys_w[127:0];

    always_comb begin
        rk_sel = keys_w[127:0];
        for (int i = 0; i <= NR; i++)
            if (rnd_q == 4'(i)) rk_sel = keys_w[128*(NR - i) +: 128];
    end

    assign out_hs = out_valid_q & out_ready;

`ifdef AES_ENC_CBC_EN
    logic [127:0] chain_q, chain_d;
    logic         iv_take;

    // chain_d doubles as the chaining value for a block accepted this cycle, so a back-to-back
    // accept in DONE chains off the ciphertext being handed over on the same edge.
    always_comb begin
        iv_take = iv_load && (state_q == S_IDLE || (state_q == S_DONE && out_hs));
        chain_d = chain_q;
        if (iv_take)     chain_d = iv_in;
        else if (out_hs) chain_d = ct_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain_q <= '0;
        else       chain_q <= chain_d;
    end

    assign chain_src = chain_d;
`else
    assign chain_src = '0;
`endif

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        key_d       = key_q;
        rnd_d       = rnd_q;
        ct_d        = ct_q;
        out_valid_d = out_valid_q;
        in_ready_c  = 1'b0;
        case (state_q)
            S_IDLE: in_ready_c = 1'b1;
            S_ROUND: begin
                st_d  = round_w;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == RND_LAST) state_d = S_FINAL;
            end
            S_FINAL: begin
                ct_d        = final_w;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                in_ready_c = out_ready;
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_hs = in_valid & in_ready_c;
        if (in_hs) begin
            key_d   = key_in;
            st_d    = pt_in ^ chain_src ^ rk0_in;
            rnd_d   = 4'd1;
            state_d = S_ROUND;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            st_q        <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            key_q       <= key_d;
            rnd_q       <= rnd_d;
            ct_q        <= ct_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_c & ~reset;
    assign ct_out    = ct_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == S_ROUND) || (state_q == S_FINAL);

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: known-answer vectors, backpressure, back-to-back, mid-block reset,
// 192/256-bit keys, and CBC chaining when AES_ENC_CBC_EN is defined.
module tb_aes_encrypt_core;
    localparam int NR = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [127:0] key_in, pt_in, ct_out;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [191:0] key192;
    logic [255:0] key256;
    logic [127:0] pt_w, ct192, ct256;
    logic         v192, v256, rdy192, rdy256, ov192, ov256, busy192, busy256;
    logic         one = 1'b1;
`ifdef AES_ENC_CBC_EN
    logic [127:0] iv_in, zero_iv = '0;
    logic         iv_load, zero_ld = 1'b0;
    logic         g_use_iv = 1'b1;
    logic [127:0] g_iv = '0;
`endif

    aes_encrypt_core #(.KEY_BITS(128)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .pt_in(pt_in), .in_valid(in_valid),
        .in_ready(in_ready), .ct_out(ct_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
`ifdef AES_ENC_CBC_EN
        , .iv_in(iv_in), .iv_load(iv_load)
`endif
    );

    aes_encrypt_core #(.KEY_BITS(192)) dut192 (
        .clk(clk), .reset(reset), .key_in(key192), .pt_in(pt_w), .in_valid(v192),
        .in_ready(rdy192), .ct_out(ct192), .out_valid(ov192), .out_ready(one), .busy(busy192)
`ifdef AES_ENC_CBC_EN
        , .iv_in(zero_iv), .iv_load(zero_ld)
`endif
    );

    aes_encrypt_core #(.KEY_BITS(256)) dut256 (
        .clk(clk), .reset(reset), .key_in(key256), .pt_in(pt_w), .in_valid(v256),
        .in_ready(rdy256), .ct_out(ct256), .out_valid(ov256), .out_ready(one), .busy(busy256)
`ifdef AES_ENC_CBC_EN
        , .iv_in(zero_iv), .iv_load(zero_ld)
`endif
    );

    typedef struct {
        logic [127:0] ct;
        int           acc;
    } exp_t;
    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[6];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: latency checked when out_valid rises, ciphertext checked on the output handshake.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_out_valid: got out_valid=1 want 0 (cycle %0d)", cyc);
                end else begin
                    chk("latency", 128'(cyc - sbq[0].acc), 128'(NR));
                end
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                chk("ct", ct_out, sbq[0].ct);
                void'(sbq.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    // Called on a falling edge; returns on the falling edge after the accepting clock edge.
    task automatic send(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                        output int acc, output int waits);
        exp_t e;
        key_in   = key;
        pt_in    = pt;
        in_valid = 1'b1;
`ifdef AES_ENC_CBC_EN
        iv_load = g_use_iv;
        iv_in   = g_iv;
`endif
        acc   = -1;
        waits = 0;
        while (acc < 0 && waits < 60) begin
            #2;
            if (in_ready) begin
                acc   = cyc + 1;
                e.ct  = ct;
                e.acc = acc;
                sbq.push_back(e);
            end
            @(negedge clk);
            if (acc < 0) waits++;
        end
        in_valid = 1'b0;
`ifdef AES_ENC_CBC_EN
        iv_load = 1'b0;
`endif
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no in_ready want accept within 60 cycles");
        end
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < bound) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("drain", 128'(sbq.size()), 128'(0));
        sbq.delete();
        @(negedge clk);
    endtask

    task automatic run_wide(input int sel, input logic [127:0] exp, input int nr);
        int k;
        bit got;
        if (sel == 0) v192 = 1'b1; else v256 = 1'b1;
        #2;
        chk(sel == 0 ? "in_ready192" : "in_ready256", (sel == 0) ? rdy192 : rdy256, 1);
        @(negedge clk);
        v192 = 1'b0;
        v256 = 1'b0;
        k    = 0;
        got  = 0;
        while (!got && k < 40) begin
            #2;
            if ((sel == 0) ? ov192 : ov256) got = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk(sel == 0 ? "latency192" : "latency256", 128'(k), 128'(nr));
        chk(sel == 0 ? "ct192" : "ct256", (sel == 0) ? ct192 : ct256, exp);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish before 300us");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, waits, spur;
        int accs[4];

        vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                  128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vt[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                  128'hf5d3d58503b9699de785895a96fdbaaf};
        vt[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h30c81c46a35ce411e5fbc1191a0a52ef,
                  128'h43b1cd7f598ece23881b00e3ed030688};
        vt[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf69f2445df4f9b17ad2b417be66c3710,
                  128'h7b0c785e27e8ad3f8223207104725dd4};
        vt[5] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        for (int i = 0; i < 32; i++) key256[255 - 8*i -: 8] = 8'(i);
        key192 = key256[255:64];
        pt_w   = 128'h00112233445566778899aabbccddeeff;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; key_in = '0; pt_in = '0;
        v192 = 1'b0; v256 = 1'b0;
`ifdef AES_ENC_CBC_EN
        iv_load = 1'b0; iv_in = '0;
`endif
        @(negedge clk);
        #2;
        chk("rst_ct_out", ct_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("in_ready_after_rst", in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send(vt[i].key, vt[i].pt, vt[i].ct, acc, waits);
            #1;
            chk("busy_running", busy, 1);
            wait_drain(40);
        end

        // Backpressure: hold DONE for five cycles with a new block pending, then release.
        out_ready = 1'b0;
        send(vt[0].key, vt[0].pt, vt[0].ct, acc, waits);
        waits = 0;
        while (!out_valid && waits < 30) begin
            @(negedge clk);
            #2;
            waits++;
        end
        key_in   = vt[1].key;
        pt_in    = vt[1].pt;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ct_hold", ct_out, vt[0].ct);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 0);
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(vt[1].key, vt[1].pt, vt[1].ct, acc, waits);
        chk("bp_same_cycle_accept", 128'(waits), 128'(0));
        wait_drain(40);

        for (int b = 0; b < 4; b++) send(vt[b + 2].key, vt[b + 2].pt, vt[b + 2].ct, accs[b], waits);
        for (int b = 1; b < 4; b++) chk("b2b_spacing", 128'(accs[b] - accs[b-1]), 128'(NR + 1));
        wait_drain(60);

        // Reset in the middle of round 5.
        send(vt[2].key, vt[2].pt, vt[2].ct, acc, waits);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #2;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_ct_out", ct_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("mid_rst_in_ready_after", in_ready, 1);
        spur = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #2;
            if (out_valid) spur++;
        end
        chk("mid_rst_no_out_valid", 128'(spur), 128'(0));
        @(negedge clk);
        send(vt[3].key, vt[3].pt, vt[3].ct, acc, waits);
        wait_drain(40);

        run_wide(0, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12);
        run_wide(1, 128'h8ea2b7ca516745bfeafc49904b496089, 14);

`ifdef AES_ENC_CBC_EN
        g_use_iv = 1'b1;
        g_iv     = 128'h000102030405060708090a0b0c0d0e0f;
        send(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
             128'h7649abac8119b246cee98e9b12e9197d, acc, waits);
        g_use_iv = 1'b0;
        wait_drain(40);
        send(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
             128'h5086cb9b507219ee95db113a917678b2, acc, waits);
        wait_drain(40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_encrypt_core.md
# aes_encrypt_core

Iterative AES block encryptor, parametrised for 128/192/256-bit keys, computing one round per clock. It wraps the team's existing KeyExpansion, round, subBytes, ShiftBytes and Addroundkey blocks behind valid/ready handshakes on input and output, with an explicit FSM and defined reset values. It sits between the block-framing logic and the ciphertext sink, and replaces free-running encrypt wrappers wherever backpressure or back-to-back blocks are needed.

## Interface
- KEY_BITS, 128, key length; legal values 128, 192, 256; any other value is a elaboration error.
- NK, KEY_BITS/32, key words; derived, do not override.
- NR, NK+6, round count (10/12/14); derived, do not override.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- key_in  in  KEY_BITS  cipher key; sampled only on input handshake.
- pt_in  in  128  plaintext block; sampled only on input handshake.
- in_valid  in  1  pt_in/key_in valid.
- in_ready  out  1  core can accept; input handshake = in_valid & in_ready.
- ct_out  out  128  ciphertext; stable while out_valid=1.
- out_valid  out  1  ct_out valid.
- out_ready  in  1  sink accepts; output handshake = out_valid & out_ready.
- busy  out  1  high in ROUND and FINAL.
- iv_in  in  128  CBC IV (AES_ENC_CBC_EN only).
- iv_load  in  1  load chain register from iv_in (AES_ENC_CBC_EN only).

## Operation
- Key register key_q (KEY_BITS) feeds KeyExpansion. Round key i = keys[128*(NR-i) +: 128], i=0..NR.
- State register st_q (128), round counter rnd_q (4 bits), FSM states IDLE, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On input handshake: key_q<=key_in; st_q<=pt_in ^ rk0 (rk0 computed from key_in directly); rnd_q<=1; -> ROUND if NR>1.
- ROUND: st_q<=round(st_q, rk[rnd_q]); rnd_q++; when rnd_q==NR-1 -> FINAL.
- FINAL: ct_out<=AddRoundKey(ShiftRows(SubBytes(st_q)), rk[NR]); out_valid<=1; -> DONE.
- DONE: out_valid=1, ct_out held. in_ready = out_ready (combinational). On output handshake without input handshake -> IDLE, out_valid<=0. On simultaneous output and input handshake: accept the new block exactly as IDLE does -> ROUND, out_valid<=0.
- in_valid outside IDLE/DONE is ignored; pt_in/key_in changes mid-block have no effect.
- busy=1 in ROUND, FINAL; else 0.

## Timing
- Reset values: ct_out=0, out_valid=0, busy=0, st_q=0, key_q=0, rnd_q=0, FSM=IDLE. in_ready=0 while reset is asserted, 1 on the first cycle after release.
- Latency: input handshake at edge T -> out_valid high after edge T+NR (10/12/14 cycles).
- Throughput: one block per NR+1 cycles with out_ready tied high (NR cycles of compute, plus one cycle in DONE that overlaps the next accept).
- out_ready low: DONE held indefinitely; ct_out, out_valid unchanged.
- Reset mid-block: computation is abandoned, no out_valid pulse, FSM=IDLE.
- rnd_q never exceeds NR; no wrap.

## Configuration
- AES_ENC_CBC_EN defined: iv_in/iv_load ports exist; 128-bit chain register chain_q, reset 0.
  - Accepted block is pt_in ^ chain_q ^ rk0.
  - On output handshake chain_q<=ct_out.
  - iv_load is honoured only in IDLE, or in DONE coincident with an output handshake, where it overrides the ct_out update.
  - iv_load coincident with an input handshake: iv_in is used in place of chain_q for that block.
  - iv_load in ROUND or FINAL is ignored.
- Not defined: pure ECB; no chain register, no iv ports; accepted block is pt_in ^ rk0.

## Test plan
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- KEY_BITS=192, key 00..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles. KEY_BITS=256, key 00..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Backpressure: out_ready low 5 cycles after out_valid -> ct_out/out_valid stable, in_ready=0; raise out_ready with in_valid high -> same-cycle accept, next ct 10 cycles later.
- Back-to-back: 4 blocks, in_valid/out_ready held high -> 4 correct cts, one accept every 11 cycles, no drops or duplicates.
- Reset pulse at round 5 -> out_valid stays 0, outputs 0, in_ready=1 after release; next block encrypts correctly.
- AES_ENC_CBC_EN: key 2b7e151628aed2a6abf7158809cf4f3c, iv_load with IV 000102...0f, pt 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d; then pt ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
